aes_inv_cipher: RTL and testbench



---
 rtl/aes_pkg.sv | 86 ++++++++
 rtl/aes_inv_cipher_if.sv | 13 +
 rtl/aes_inv_sbox.sv | 18 +
 rtl/aes_sbox.sv | 18 +
 rtl/aes_inv_cipher.sv | 135 +++++++++++++
 tb/tb_aes_inv_cipher.sv | 256 +++++++++++++++++++++++++
 6 files changed

// File: rtl/aes_pkg.sv
// Shared AES inverse-cipher definitions: FSM encoding, Rcon table,
// GF(2^8) helpers and the byte-wise state transforms used by the datapath.
package aes_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXPAND,
    ST_INIT,
    ST_ROUND,
    ST_FINAL
  } fsm_t;

  // Rcon[1..10]; only the top byte of the round constant word is nonzero
  localparam logic [1:10][7:0] RCON_TAB = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] rcon(input logic [3:0] j);
    return RCON_TAB[j];
  endfunction

  function automatic int nr_of(input int nk);
    return nk + 6;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul9(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] mulb(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] muld(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] mule(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

  // MSB position of state byte s(r,c); byte 0 = s(0,0) sits at [127:120]
  function automatic int byte_pos(input int r, input int c);
    return 127 - 8 * (4 * c + r);
  endfunction

  function automatic logic [7:0] get_byte(input logic [127:0] s, input int r, input int c);
    return s[byte_pos(r, c) -: 8];
  endfunction

  // Row r is rotated right by r positions
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[byte_pos(r, c) -: 8] = get_byte(s, r, (c + 4 - r) % 4);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = get_byte(s, 0, c);
      a1 = get_byte(s, 1, c);
      a2 = get_byte(s, 2, c);
      a3 = get_byte(s, 3, c);
      o[byte_pos(0, c) -: 8] = mule(a0) ^ mulb(a1) ^ muld(a2) ^ mul9(a3);
      o[byte_pos(1, c) -: 8] = mul9(a0) ^ mule(a1) ^ mulb(a2) ^ muld(a3);
      o[byte_pos(2, c) -: 8] = muld(a0) ^ mul9(a1) ^ mule(a2) ^ mulb(a3);
      o[byte_pos(3, c) -: 8] = mulb(a0) ^ muld(a1) ^ mul9(a2) ^ mule(a3);
    end
    return o;
  endfunction

  function automatic logic [127:0] add_round_key(input logic [127:0] s, input logic [127:0] k);
    return s ^ k;
  endfunction

endpackage

// File: rtl/aes_inv_cipher_if.sv
// Start/data/result bundle between a controller (master) and the
// inverse cipher core (slave).
interface aes_inv_cipher_if;
  logic         enable;
  logic [255:0] key_in;
  logic [127:0] data_in;
  logic [127:0] data_out;
  logic         done;
  logic         busy;

  modport master (output enable, key_in, data_in, input data_out, done, busy);
  modport slave  (input enable, key_in, data_in, output data_out, done, busy);
endinterface

// File: rtl/aes_inv_sbox.sv
// Inverse AES S-box, 8-bit combinational lookup (decryption datapath).
module aes_inv_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [0:255][7:0] ISBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  assign y = ISBOX[a];
endmodule

// File: rtl/aes_sbox.sv
// Forward AES S-box, 8-bit combinational lookup (key expansion only).
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y = SBOX[a];
endmodule

// File: rtl/aes_inv_cipher.sv
// Iterative AES inverse cipher: on-chip key expansion (one word per cycle)
// into a local round-key store, then one inverse round per cycle.
module aes_inv_cipher
  import aes_pkg::*;
#(
  parameter int NK = 4
) (
  input  logic             clk,
  input  logic             rst,
  aes_inv_cipher_if.slave  bus
);
  localparam int         NR     = nr_of(NK);
  localparam int         NW     = 4 * (NR + 1);
  localparam logic [5:0] LAST_W = 6'(NW - 1);

  if (NK != 4 && NK != 6 && NK != 8) begin : g_nk_check
    $error("aes_inv_cipher: NK must be 4, 6 or 8");
  end

  fsm_t         fsm_reg;
  logic [5:0]   wcnt_reg;    // index i of the word being expanded
  logic [3:0]   round_reg;   // doubles as the round-key index in INIT/ROUND/FINAL
  logic [127:0] ct_reg;
  logic [127:0] state_reg;
  logic [127:0] data_out_reg;
  logic         done_reg;
  logic         busy_reg;
  logic [31:0]  w_mem [NW];

  // Key expansion: w[i] = w[i-NK] ^ f(w[i-1])
  logic [31:0] w_prev, w_back, sub_in, sub_out, w_new;
  logic        rot_step, sub_step;

  assign w_prev   = w_mem[wcnt_reg - 6'd1];
  assign w_back   = w_mem[wcnt_reg - 6'(NK)];
  assign rot_step = (int'(wcnt_reg) % NK) == 0;
  assign sub_step = (NK == 8) && (wcnt_reg[2:0] == 3'd4);
  assign sub_in   = rot_step ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_sub
    aes_sbox u_sbox (.a(sub_in[8*gi +: 8]), .y(sub_out[8*gi +: 8]));
  end

  // Select the transform applied to w[i-1] before folding in w[i-NK]
  always_comb begin
    w_new = w_back ^ w_prev;
    if (rot_step)
      w_new = w_back ^ sub_out ^ {rcon(4'(int'(wcnt_reg) / NK)), 24'h000000};
    else if (sub_step)
      w_new = w_back ^ sub_out;
  end

  // Round datapath
  logic [5:0]   rk_base;
  logic [127:0] rk, shifted, subbed, keyed, round_out;

  assign rk_base   = {round_reg, 2'b00};
  assign rk        = {w_mem[rk_base], w_mem[rk_base + 6'd1],
                      w_mem[rk_base + 6'd2], w_mem[rk_base + 6'd3]};
  assign shifted   = inv_shift_rows(state_reg);
  assign keyed     = add_round_key(subbed, rk);
  assign round_out = inv_mix_columns(keyed);

  for (gi = 0; gi < 16; gi++) begin : g_isb
    aes_inv_sbox u_isbox (.a(shifted[8*gi +: 8]), .y(subbed[8*gi +: 8]));
  end

  // Round-key store writes: key words at start, one expanded word per cycle
  always_ff @(posedge clk) begin
    if (fsm_reg == ST_IDLE && bus.enable) begin
      for (int j = 0; j < NK; j++)
        w_mem[j] <= bus.key_in[255 - 32*j -: 32];
    end else if (fsm_reg == ST_EXPAND) begin
      w_mem[wcnt_reg] <= w_new;
    end
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_reg      <= ST_IDLE;
      wcnt_reg     <= '0;
      round_reg    <= '0;
      ct_reg       <= '0;
      state_reg    <= '0;
      data_out_reg <= '0;
      done_reg     <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (fsm_reg)
        ST_IDLE: begin
          if (bus.enable) begin
            ct_reg   <= bus.data_in;
            wcnt_reg <= 6'(NK);  // words 0..NK-1 come straight from the key
            busy_reg <= 1'b1;
            fsm_reg  <= ST_EXPAND;
          end
        end
        ST_EXPAND: begin
          wcnt_reg <= wcnt_reg + 6'd1;
          if (wcnt_reg == LAST_W) begin
            wcnt_reg  <= '0;
            round_reg <= 4'(NR);
            fsm_reg   <= ST_INIT;
          end
        end
        ST_INIT: begin
          state_reg <= add_round_key(ct_reg, rk);
          round_reg <= 4'(NR - 1);
          fsm_reg   <= ST_ROUND;
        end
        ST_ROUND: begin
          state_reg <= round_out;
          round_reg <= round_reg - 4'd1;
          if (round_reg == 4'd1)
            fsm_reg <= ST_FINAL;
        end
        ST_FINAL: begin
          data_out_reg <= keyed;
          done_reg     <= 1'b1;
          busy_reg     <= 1'b0;
          fsm_reg      <= ST_IDLE;
        end
        default: fsm_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.data_out = data_out_reg;
  assign bus.done     = done_reg;
  assign bus.busy     = busy_reg;

endmodule

// File: tb/tb_aes_inv_cipher.sv
// Bench for aes_inv_cipher: one instance per key size (NK = 4, 6, 8),
// FIPS-197 vectors, enable/reset corner sequences and encrypt->decrypt loopback.
module tb_aes_inv_cipher;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [2:0]          en_v;
  logic [2:0][255:0]   key_v;
  logic [2:0][127:0]   ct_v;
  wire  [2:0][127:0]   dout_v;
  wire  [2:0]          done_v;
  wire  [2:0]          busy_v;

  int errors = 0;
  int checks = 0;

  genvar gi;
  for (gi = 0; gi < 3; gi++) begin : g_dut
    aes_inv_cipher_if bus ();
    assign bus.enable  = en_v[gi];
    assign bus.key_in  = key_v[gi];
    assign bus.data_in = ct_v[gi];
    assign dout_v[gi]  = bus.data_out;
    assign done_v[gi]  = bus.done;
    assign busy_v[gi]  = bus.busy;
    aes_inv_cipher #(.NK(4 + 2*gi)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  end

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- reference encryption model ----------------
  logic [7:0] sbox_t [256];

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] xx;
    xx = {x, x};
    return xx[15 - n -: 8];
  endfunction

  function automatic logic [127:0] aes_encrypt(input int nk, input logic [255:0] k,
                                               input logic [127:0] pt);
    int nr;
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc, a0, a1, a2, a3;
    logic [7:0]  s [16];
    logic [7:0]  u [16];
    logic [127:0] o;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = k[255 - 32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end else if (nk == 8 && i % 8 == 4) begin
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8];
    for (int r = 0; r <= nr; r++) begin
      if (r > 0) begin
        for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
        for (int c = 0; c < 4; c++)
          for (int j = 0; j < 4; j++) u[4*c + j] = s[4*((c + j) % 4) + j];
        s = u;
        if (r < nr) begin
          for (int c = 0; c < 4; c++) begin
            a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
            s[4*c]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
            s[4*c+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
            s[4*c+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
            s[4*c+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
          end
        end
      end
      for (int c = 0; c < 4; c++)
        for (int j = 0; j < 4; j++) s[4*c + j] ^= w[4*r + c][31 - 8*j -: 8];
    end
    o = '0;
    for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = s[i];
    return o;
  endfunction

  // ---------------- one complete operation ----------------
  task automatic run_op(input int d, input logic [255:0] k, input logic [127:0] c,
                        input logic [127:0] pt, input int lat, input string nm);
    int n;
    @(negedge clk);
    key_v[d] = k; ct_v[d] = c; en_v[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    // scramble inputs after the start edge: the core must use its captured copy
    en_v[d] = 1'b0; key_v[d] = ~k; ct_v[d] = ~c;
    n = 0;
    check({nm, " busy_after_start"}, 256'(busy_v[d]), 256'(1'b1));
    while (!done_v[d] && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({nm, " latency"}, 256'(n), 256'(lat));
    check({nm, " data_out"}, 256'(dout_v[d]), 256'(pt));
    check({nm, " busy_in_done_cycle"}, 256'(busy_v[d]), 256'(1'b0));
    @(negedge clk);
    check({nm, " done_single_pulse"}, 256'(done_v[d]), 256'(1'b0));
    $display("op %s nk=%0d cycles=%0d ct=%h pt=%h", nm, 4 + 2*d, n, c, dout_v[d]);
  endtask

  typedef struct {
    int           d;
    logic [255:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
    int           lat;
    string        nm;
  } vec_t;

  vec_t vecs [3];
  int   lat_tab [3] = '{51, 59, 67};

  initial begin
    #900us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nd, first;
    logic [127:0] got, pt2, ct2, rpt;
    logic [255:0] rkey;

    for (int i = 0; i < 256; i++) begin
      logic [7:0] inv, b;
      b = 8'(i);
      inv = 8'h01;
      for (int e = 0; e < 254; e++) inv = gm(inv, b);
      sbox_t[i] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end

    vecs[0] = '{0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                128'h00112233445566778899aabbccddeeff, 51, "fips_c1"};
    vecs[1] = '{1, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0},
                128'hdda97ca4864cdfe06eaf70a0ec0d7191,
                128'h00112233445566778899aabbccddeeff, 59, "fips_c2"};
    vecs[2] = '{2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                128'h8ea2b7ca516745bfeafc49904b496089,
                128'h00112233445566778899aabbccddeeff, 67, "fips_c3"};

    rst = 1'b0; en_v = '0; key_v = '0; ct_v = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset nk%0d data_out", 4 + 2*d), 256'(dout_v[d]), 256'(0));
      check($sformatf("reset nk%0d done", 4 + 2*d), 256'(done_v[d]), 256'(0));
      check($sformatf("reset nk%0d busy", 4 + 2*d), 256'(busy_v[d]), 256'(0));
    end
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 3; i++)
      run_op(vecs[i].d, vecs[i].key, vecs[i].ct, vecs[i].pt, vecs[i].lat, vecs[i].nm);

    // enable re-pulsed while busy, then back-to-back start in the done cycle
    pt2 = 128'h0123456789abcdeffedcba9876543210;
    ct2 = aes_encrypt(4, vecs[0].key, pt2);
    @(negedge clk);
    key_v[0] = vecs[0].key; ct_v[0] = vecs[0].ct; en_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    en_v[0] = 1'b0; n = 0;
    while (!done_v[0] && n < 200) begin
      @(negedge clk);
      n++;
      en_v[0] = (n == 4 || n == 29);
    end
    check("repulse latency", 256'(n), 256'(51));
    check("repulse data_out", 256'(dout_v[0]), 256'(vecs[0].pt));
    $display("op repulse nk=4 cycles=%0d pt=%h", n, dout_v[0]);
    ct_v[0] = ct2; en_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    en_v[0] = 1'b0; nd = 0; first = -1; got = '0;
    for (n = 0; n <= 60; n++) begin
      if (done_v[0]) begin
        nd++;
        if (first < 0) begin first = n; got = dout_v[0]; end
      end
      @(negedge clk);
    end
    check("b2b done count", 256'(nd), 256'(1));
    check("b2b latency", 256'(first), 256'(51));
    check("b2b data_out", 256'(got), 256'(pt2));
    $display("op back_to_back nk=4 cycles=%0d pt=%h", first, got);

    // reset asserted mid-operation
    @(negedge clk);
    key_v[0] = vecs[0].key; ct_v[0] = vecs[0].ct; en_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    en_v[0] = 1'b0; n = 0;
    while (n < 45) begin
      @(negedge clk);
      n++;
    end
    rst = 1'b0;
    #1;
    check("midreset busy", 256'(busy_v[0]), 256'(0));
    check("midreset data_out", 256'(dout_v[0]), 256'(0));
    check("midreset done", 256'(done_v[0]), 256'(0));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    nd = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (done_v[0]) nd++;
    end
    check("midreset no done", 256'(nd), 256'(0));
    $display("op midreset nk=4 done_pulses=%0d", nd);
    run_op(0, vecs[0].key, vecs[0].ct, vecs[0].pt, 51, "post_reset");

    // loopback against the reference encryption model
    for (int d = 0; d < 3; d++) begin
      for (int it = 0; it < 200; it++) begin
        rkey = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        rpt  = {$urandom, $urandom, $urandom, $urandom};
        run_op(d, rkey, aes_encrypt(4 + 2*d, rkey, rpt), rpt, lat_tab[d], "loop");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
